// File: rtl/fifo_flit_dispatcher.sv
// Read side of the router flit FIFO: pops {children, flit} entries, drops invalid flits,
// and replays each valid flit once per child (at least once) on a valid/ready link.
module fifo_flit_dispatcher #(
    parameter int FlitWidth     = 82,
    parameter int ChildrenWidth = 3,
    parameter int CntWidth      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fifo_empty,
    input  logic [FlitWidth+ChildrenWidth-1:0] fifo_data,
    output logic                               fifo_rd_en,
    output logic [FlitWidth-1:0]               out_flit,
    output logic [ChildrenWidth-1:0]           out_copy,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic [CntWidth-1:0]                sent_count,
    output logic [CntWidth-1:0]                drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [FlitWidth-1:0]     r_flit;
    logic [ChildrenWidth-1:0] r_copy;
    logic [ChildrenWidth-1:0] r_hold_n;
    logic                     r_last;
    logic [CntWidth-1:0]      r_sent;
    logic [CntWidth-1:0]      r_drop;

    logic                     w_rd_en;
    logic [FlitWidth-1:0]     w_in_flit;
    logic [ChildrenWidth-1:0] w_in_children;
    logic [ChildrenWidth-1:0] w_copy_inc;

    assign w_in_flit     = fifo_data[FlitWidth-1:0];
    assign w_in_children = fifo_data[FlitWidth+ChildrenWidth-1:FlitWidth];
    assign w_copy_inc    = r_copy + ChildrenWidth'(1);

    // Pop decision is combinational so a new read overlaps the last-copy handshake.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_rd_en = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                w_next = w_in_flit[FlitWidth-1] ? SEND : IDLE;
            end
            SEND: begin
                if (out_ready && r_last) begin
                    if (!fifo_empty) begin
                        w_rd_en = 1'b1;
                        w_next  = WAIT;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            w_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_flit   <= '0;
            r_copy   <= '0;
            r_hold_n <= '0;
            r_last   <= 1'b0;
            r_sent   <= '0;
            r_drop   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                WAIT: begin
                    if (w_in_flit[FlitWidth-1]) begin
                        r_flit   <= w_in_flit;
                        r_hold_n <= w_in_children;
                        r_copy   <= '0;
                        r_last   <= (w_in_children <= ChildrenWidth'(1));
                    end else begin
                        r_drop <= r_drop + CntWidth'(1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        r_sent <= r_sent + CntWidth'(1);
                        if (!r_last) begin
                            r_copy <= w_copy_inc;
                            r_last <= (w_copy_inc == r_hold_n - ChildrenWidth'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_flit   = r_flit;
    assign out_copy   = r_copy;
    assign out_last   = r_last;
    assign out_valid  = (r_state == SEND);
    assign busy       = (r_state != IDLE);
    assign sent_count = r_sent;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_fifo_flit_dispatcher.sv
// Directed and randomized bench for fifo_flit_dispatcher with a queue-based FIFO and
// an expected-beat scoreboard derived from the copy-replay rules.
module tb_fifo_flit_dispatcher;

    localparam int FW = 82;
    localparam int CW = 3;
    localparam int NW = 16;

    typedef struct packed {
        logic [FW-1:0] flit;
        logic [CW-1:0] copy;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty = 1'b1;
    logic [FW+CW-1:0] fifo_data = '0;
    logic             fifo_rd_en;
    logic [FW-1:0]    out_flit;
    logic [CW-1:0]    out_copy;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [NW-1:0]    sent_count;
    logic [NW-1:0]    drop_count;

    logic [FW+CW-1:0] q[$];
    beat_t            exp_q[$];
    logic             pop_req = 1'b0;
    int unsigned      m_sent = 0;
    int unsigned      m_drop = 0;
    int unsigned      checks = 0;
    int unsigned      errors = 0;

    fifo_flit_dispatcher #(
        .FlitWidth    (FW),
        .ChildrenWidth(CW),
        .CntWidth     (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .out_flit  (out_flit),
        .out_copy  (out_copy),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sent_count(sent_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // FIFO model: pop strobe sampled mid-cycle, registered read data appears just after the edge.
    always @(negedge clk) pop_req = fifo_rd_en;
    always @(posedge clk) begin
        #1;
        if (pop_req && q.size() != 0) begin
            fifo_data  = q.pop_front();
            fifo_empty = (q.size() == 0);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int unsigned ch, input logic v, input logic [FW-2:0] p);
        logic [FW-1:0] f;
        int unsigned   n;
        f = {v, p};
        q.push_back({ch[CW-1:0], f});
        fifo_empty = 1'b0;
        n = (ch == 0) ? 1 : ch;
        if (v) begin
            for (int unsigned i = 0; i < n; i++) begin
                exp_q.push_back('{flit: f, copy: i[CW-1:0], last: (i == n - 1)});
            end
        end else begin
            m_drop++;
        end
    endtask

    task automatic tick();
        beat_t b;
        @(negedge clk);
        check("pop_when_empty", {127'd0, fifo_rd_en && fifo_empty}, 128'd0);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 128'd1, 128'd0);
            end else begin
                b = exp_q.pop_front();
                check("beat_flit", {46'd0, out_flit}, {46'd0, b.flit});
                check("beat_copy", {125'd0, out_copy}, {125'd0, b.copy});
                check("beat_last", {127'd0, out_last}, {127'd0, b.last});
                m_sent++;
            end
        end
        @(posedge clk);
        #3;
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check("timeout_valid", {127'd0, out_valid}, 128'd1);
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("timeout_idle", {127'd0, busy || (q.size() != 0)}, 128'd0);
    endtask

    initial begin
        logic [95:0]   rnd;
        logic [FW-1:0] fexp;

        // Reset held with a non-empty FIFO
        rst       = 1'b1;
        out_ready = 1'b1;
        push(0, 1'b1, 81'h11);
        tick();
        tick();
        check("rst_rd_en", {127'd0, fifo_rd_en}, 128'd0);
        check("rst_valid", {127'd0, out_valid}, 128'd0);
        check("rst_flit", {46'd0, out_flit}, 128'd0);
        check("rst_copy", {125'd0, out_copy}, 128'd0);
        check("rst_last", {127'd0, out_last}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_sent", {112'd0, sent_count}, 128'd0);
        check("rst_drop", {112'd0, drop_count}, 128'd0);
        check("rst_q_untouched", q.size(), 128'd1);
        rst = 1'b0;
        #1;
        check("first_pop", {127'd0, fifo_rd_en}, 128'd1);
        tick();
        check("wait_busy", {127'd0, busy}, 128'd1);
        check("wait_no_valid", {127'd0, out_valid}, 128'd0);
        check("wait_no_pop", {127'd0, fifo_rd_en}, 128'd0);
        tick();
        check("lat2_valid", {127'd0, out_valid}, 128'd1);
        check("leaf_copy", {125'd0, out_copy}, 128'd0);
        check("leaf_last", {127'd0, out_last}, 128'd1);
        wait_idle(20);
        check("leaf_sent", {112'd0, sent_count}, 128'd1);

        // Three children, payload A5
        push(3, 1'b1, 81'hA5);
        wait_idle(30);
        check("multi_sent", {112'd0, sent_count}, 128'd4);
        check("multi_drained", exp_q.size(), 128'd0);

        // Invalid entry is dropped
        push(5, 1'b0, 81'h3);
        wait_idle(20);
        check("drop_count", {112'd0, drop_count}, 128'd1);
        check("drop_sent", {112'd0, sent_count}, 128'd4);

        // Stall mid-flit with another entry queued
        out_ready = 1'b0;
        push(4, 1'b1, 81'h5C);
        push(0, 1'b1, 81'h3C);
        wait_valid(20);
        fexp = {1'b1, 81'h5C};
        repeat (4) begin
            tick();
            check("stall_flit", {46'd0, out_flit}, {46'd0, fexp});
            check("stall_copy", {125'd0, out_copy}, 128'd0);
            check("stall_no_pop", {127'd0, fifo_rd_en}, 128'd0);
            check("stall_q", q.size(), 128'd1);
        end
        out_ready = 1'b1;
        wait_idle(40);
        check("stall_sent", {112'd0, sent_count}, 128'd9);

        // Back-to-back single-copy flits
        push(1, 1'b1, 81'h61);
        push(1, 1'b1, 81'h62);
        wait_valid(20);
        check("b2b_pop_on_last", {127'd0, fifo_rd_en}, 128'd1);
        tick();
        check("b2b_gap", {127'd0, out_valid}, 128'd0);
        tick();
        check("b2b_second", {127'd0, out_valid}, 128'd1);
        check("b2b_second_flit", {46'd0, out_flit}, {46'd0, 1'b1, 81'h62});
        wait_idle(20);
        check("b2b_sent", {112'd0, sent_count}, 128'd11);

        // Reset during copy 1 of 4
        push(4, 1'b1, 81'h77);
        wait_valid(20);
        tick();
        check("pre_rst_copy", {125'd0, out_copy}, 128'd1);
        rst = 1'b1;
        exp_q.delete();
        m_sent = 0;
        m_drop = 0;
        #1;
        check("rst_mid_rd_en", {127'd0, fifo_rd_en}, 128'd0);
        tick();
        check("rst_mid_valid", {127'd0, out_valid}, 128'd0);
        check("rst_mid_busy", {127'd0, busy}, 128'd0);
        check("rst_mid_flit", {46'd0, out_flit}, 128'd0);
        check("rst_mid_sent", {112'd0, sent_count}, 128'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("abandoned", {127'd0, busy}, 128'd0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                push($urandom_range(0, 7), ($urandom_range(0, 3) != 0), rnd[FW-2:0]);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(3000);
        check("rand_sent", {112'd0, sent_count}, {112'd0, 16'(m_sent)});
        check("rand_drop", {112'd0, drop_count}, {112'd0, 16'(m_drop)});
        check("rand_drained", exp_q.size(), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
